// File: rtl/boot_loader.sv
// Byte-stream program loader: receives a length-prefixed, XOR-checksummed image,
// writes it word by word into program RAM and releases the CPU on a good checksum.
module boot_loader #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

    state_t                  r_state;
    state_t                  w_next;
    logic [15:0]             r_len;
    logic [1:0]              r_bcnt;
    logic [DATA_WIDTH-9:0]   r_word;
    logic [7:0]              r_csum;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_data;

    logic                    w_active;
    logic                    w_xfer;
    logic [15:0]             w_len;
    logic                    w_last_word;

    assign w_active    = (r_state != S_RUN) && (r_state != S_ERROR);
    // rx_ready is gated by rst so it drops the moment reset asserts and rises as soon as it releases
    assign rx_ready    = !rst && w_active;
    assign w_xfer      = rx_valid && rx_ready;
    assign w_len       = {r_len[15:8], rx_data};
    // r_addr still holds the index of the word being assembled when its 4th byte arrives
    assign w_last_word = (16'(r_addr) == r_len - 16'd1);

    assign mem_we   = r_we;
    assign mem_addr = r_addr;
    assign mem_data = r_data;
    assign cpu_rst  = (r_state != S_RUN);
    assign done     = (r_state == S_RUN);
    assign error    = (r_state == S_ERROR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_LEN_HI;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LEN_HI: if (w_xfer) w_next = S_LEN_LO;
            S_LEN_LO: begin
                if (w_xfer) begin
                    if (w_len == 16'd0)                 w_next = S_CHECK;
                    else if ({1'b0, w_len} > MAX_WORDS) w_next = S_ERROR;
                    else                                w_next = S_DATA;
                end
            end
            S_DATA:   if (w_xfer && r_bcnt == 2'd3 && w_last_word) w_next = S_CHECK;
            S_CHECK:  if (w_xfer) w_next = (rx_data == r_csum) ? S_RUN : S_ERROR;
            default:  w_next = r_state;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len  <= '0;
            r_bcnt <= '0;
            r_word <= '0;
            r_csum <= '0;
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_we <= 1'b0;
            // advance after a write only if more words follow, so the address never runs past N-1
            if (r_we && r_state == S_DATA) r_addr <= r_addr + 1'b1;
            if (w_xfer) begin
                case (r_state)
                    S_LEN_HI: r_len[15:8] <= rx_data;
                    S_LEN_LO: r_len[7:0]  <= rx_data;
                    S_DATA: begin
                        r_bcnt <= r_bcnt + 2'd1;
                        r_word <= {r_word[DATA_WIDTH-17:0], rx_data};
                        r_csum <= r_csum ^ rx_data;
                        if (r_bcnt == 2'd3) begin
                            r_we   <= 1'b1;
                            r_data <= {r_word, rx_data};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
